// File: rtl/multiplier_lut.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_lut
// Brief    : 2x2-bit unsigned multiplier from a 16-entry LUT, with a registered
//            product and an optional sticky self-check (MULTIPLIER_LUT_SELFCHECK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_lut (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] b,
    input  logic [1:0] a,
    output logic [3:0] z,
    output logic [3:0] z_q,
    output logic       chk_err
);

    // Entry i lives at bits [4*i +: 4]; index is {a,b}, entry 15 is the MSB nibble.
    localparam logic [63:0] c_lut = {
        4'd9, 4'd6, 4'd3, 4'd0,
        4'd6, 4'd4, 4'd2, 4'd0,
        4'd3, 4'd2, 4'd1, 4'd0,
        4'd0, 4'd0, 4'd0, 4'd0
    };

    logic [5:0] w_lut_base;
    logic [1:0] r_rst_sync;
    logic       w_run;
    logic [3:0] r_z_q;

    assign w_lut_base = {a, b, 2'b00};
    assign z          = c_lut[w_lut_base +: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    // Capture is released once the first stage sees reset gone, so the first
    // product lands on the second rising edge after release.
    assign w_run = |r_rst_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z_q <= 4'h0;
        end else if (w_run) begin
            r_z_q <= z;
        end
    end

    assign z_q = r_z_q;

`ifdef MULTIPLIER_LUT_SELFCHECK_EN
    logic [3:0] w_arith;
    logic       r_chk_err;

    assign w_arith = {2'b00, a} * {2'b00, b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_err <= 1'b0;
        end else if (w_run && (z != w_arith)) begin
            r_chk_err <= 1'b1;
        end
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multiplier_lut.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplier_lut
// Brief    : Self-checking bench for multiplier_lut against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplier_lut;

    logic       clk;
    logic       rst_n;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] z;
    logic [3:0] z_q;
    logic       chk_err;

    int total = 0;
    int bad   = 0;

    // Model state: expected registered product and edges seen since release.
    int exp_zq    = 0;
    int rel_edges = 0;

    multiplier_lut dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .b       (b),
        .a       (a),
        .z       (z),
        .z_q     (z_q),
        .chk_err (chk_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the registered view.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_zq    = 0;
            rel_edges = 0;
        end else begin
            rel_edges++;
            if (rel_edges >= 2) exp_zq = int'(a) * int'(b);
        end
    end

    // Per-cycle comparison, inputs are stable here (they change 1 after negedge).
    always @(negedge clk) begin
        check("z_model", int'(z), int'(a) * int'(b));
        check("zq_model", int'(z_q), exp_zq);
        check("chk_err", int'(chk_err), 0);
    end

    task automatic apply(input int av, input int bv);
        @(negedge clk);
        #1;
        a = 2'(av);
        b = 2'(bv);
    endtask

    task automatic apply_check(input int av, input int bv, input int zexp);
        apply(av, bv);
        #2;
        check("z_lit", int'(z), zexp);
    endtask

    initial begin
        rst_n = 1'b0;
        a     = 2'd3;
        b     = 2'd3;

        // Reset held: combinational path live, registers cleared.
        repeat (2) @(negedge clk);
        #2;
        check("rst_z", int'(z), 9);
        check("rst_zq", int'(z_q), 0);
        check("rst_chk", int'(chk_err), 0);

        // Release: first capture on the second rising edge.
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_edge1_zq", int'(z_q), 0);
        @(posedge clk);
        #1;
        check("rel_edge2_zq", int'(z_q), 9);

        // Zero and boundary vectors.
        apply_check(0, 0, 0);
        apply_check(0, 2, 0);
        apply_check(2, 1, 2);
        apply_check(2, 2, 4);
        apply_check(3, 0, 0);
        apply_check(3, 3, 9);

        // Exhaustive sweep, z_q checked one edge later by the compare process.
        for (int i = 0; i < 16; i++) apply(i / 4, i % 4);

        // Mid-stream asynchronous reset.
        apply(3, 2);
        @(negedge clk);
        #2;
        check("mid_zq_before", int'(z_q), 6);
        rst_n = 1'b0;
        #1;
        check("mid_zq_async", int'(z_q), 0);
        check("mid_z_kept", int'(z), 6);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rel_zq", int'(z_q), 6);

        // Random regression.
        for (int i = 0; i < 1000; i++) apply(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));

        repeat (2) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
